// File: rtl/fft_pkg.sv
// fft_pkg: shared address width, unloader state type and index helpers.
// Contents:
//   ADDR_W          - SRAM word address width (10 bits, up to 1024 points)
//   unload_state_t  - IDLE / ISSUE / DRAIN / DONE
//   points_from_cfg - point count N = 8 << cfg
//   bitrev10        - reverse the low log2n bits of an index, zero-padded to ADDR_W
package fft_pkg;

    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} unload_state_t;

    function automatic logic [10:0] points_from_cfg(input logic [2:0] cfg);
        return 11'd8 << cfg;
    endfunction

    // Reverse all ADDR_W bits, then shift the reversed field down so only the
    // low log2n bits of idx take part (idx < 2**log2n, so upper bits are 0).
    function automatic logic [ADDR_W-1:0] bitrev10(input logic [ADDR_W-1:0] idx,
                                                   input logic [3:0] log2n);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++)
            r[i] = idx[ADDR_W-1-i];
        return r >> (4'(ADDR_W) - log2n);
    endfunction

endpackage

// File: rtl/unload_skid_fifo.sv
// unload_skid_fifo: synchronous FIFO with occupancy count, used as the skid buffer
// between fixed-latency SRAM reads and the backpressured host port.
// Ports:
//   clk, i_resetn       - clock, asynchronous active-low reset
//   i_push / i_din      - write strobe and word
//   i_pop               - read strobe (ignored when empty)
//   o_dout              - head word, stable until popped
//   o_count / o_empty   - occupancy
module unload_skid_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          i_resetn,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    output logic [W-1:0]  o_dout,
    output logic [CW-1:0] o_count,
    output logic          o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop & ~o_empty;
    assign o_dout  = r_mem[r_rd];
    assign o_count = r_count;

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push)
                r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
            if (w_pop)
                r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr] <= i_din;
    end

endmodule

// File: rtl/fft_result_unloader.sv
// fft_result_unloader: streams the finished FFT from the ping-pong result SRAM to the
// host over valid/ready, using a credit-limited skid FIFO to absorb SRAM read latency.
// Build option: define FFT_UNLOAD_BITREV_EN to read in bit-reversed address order
// (host then sees natural order); otherwise addresses are issued 0..N-1.
// Ports:
//   clk, i_resetn                 - clock, asynchronous active-low reset
//   i_point_configuration         - N = 8 << cfg, sampled at arm
//   i_fft_done                    - rising edge arms the unload
//   i_sram_read_register          - bank holding the result, sampled at arm
//   o_sram_rd_en/_bank/_addr      - SRAM read request
//   i_sram_rd_data                - read data, SRAM_LAT cycles after o_sram_rd_en
//   o_data/o_valid/i_ready/o_last - host stream
//   o_busy, o_unload_done         - status
module fft_result_unloader
    import fft_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SRAM_LAT   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              i_resetn,
    input  logic [2:0]        i_point_configuration,
    input  logic              i_fft_done,
    input  logic              i_sram_read_register,
    output logic              o_sram_rd_en,
    output logic              o_sram_rd_bank,
    output logic [ADDR_W-1:0] o_sram_rd_addr,
    input  logic [DATA_W-1:0] i_sram_rd_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_unload_done
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if (SRAM_LAT < 1 || SRAM_LAT > 3) begin : g_bad_lat
        $error("fft_result_unloader: SRAM_LAT must be 1..3");
    end
    if (FIFO_DEPTH < SRAM_LAT + 2) begin : g_bad_depth
        $error("fft_result_unloader: FIFO_DEPTH must be >= SRAM_LAT+2");
    end

    unload_state_t       r_state;
    unload_state_t       w_next;
    logic                r_done_q;
    logic [2:0]          r_cfg;
    logic                r_bank;
    logic [10:0]         r_idx;
    logic [SRAM_LAT-1:0] r_pipe;
    logic [SRAM_LAT-1:0] r_tag;
    logic [10:0]         w_n;
    logic                w_arm;
    logic                w_last_idx;
    logic                w_credit;
    logic                w_rd_en;
    logic                w_pop;
    logic                w_empty;
    logic [CW-1:0]       w_count;
    logic [DATA_W:0]     w_dout;
    int                  w_inflight;

    assign w_n        = points_from_cfg(r_cfg);
    assign w_arm      = i_fft_done & ~r_done_q;
    assign w_last_idx = (r_idx == w_n - 11'd1);
    assign o_valid    = ~w_empty;
    assign w_pop      = o_valid & i_ready;
    assign o_data     = o_valid ? w_dout[DATA_W-1:0] : '0;
    assign o_last     = o_valid & w_dout[DATA_W];
    assign o_sram_rd_en   = w_rd_en;
    assign o_sram_rd_bank = r_bank;
    assign o_busy         = (r_state == ISSUE) || (r_state == DRAIN);
    assign o_unload_done  = (r_state == DONE);

`ifdef FFT_UNLOAD_BITREV_EN
    assign o_sram_rd_addr = bitrev10(r_idx[ADDR_W-1:0], {1'b0, r_cfg} + 4'd3);
`else
    assign o_sram_rd_addr = r_idx[ADDR_W-1:0];
`endif

    // Reads still in the SRAM pipe already own a FIFO slot.
    always_comb begin
        w_inflight = 0;
        for (int i = 0; i < SRAM_LAT; i++)
            w_inflight += int'(r_pipe[i]);
    end

    assign w_credit = (int'(w_count) + w_inflight) < FIFO_DEPTH;

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        case (r_state)
            IDLE:  if (w_arm) w_next = ISSUE;
            ISSUE: begin
                w_rd_en = w_credit;
                if (w_credit && w_last_idx) w_next = DRAIN;
            end
            DRAIN: if (w_pop && o_last) w_next = DONE;
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state  <= IDLE;
            r_done_q <= 1'b0;
            r_cfg    <= '0;
            r_bank   <= 1'b0;
            r_idx    <= '0;
            r_pipe   <= '0;
            r_tag    <= '0;
        end else begin
            r_state  <= w_next;
            r_done_q <= i_fft_done;
            if (r_state == IDLE && w_arm) begin
                r_cfg  <= i_point_configuration;
                r_bank <= i_sram_read_register;
                r_idx  <= '0;
            end else if (w_rd_en) begin
                r_idx <= r_idx + 11'd1;
            end
            r_pipe[0] <= w_rd_en;
            r_tag[0]  <= w_rd_en & w_last_idx;
            for (int i = 1; i < SRAM_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
                r_tag[i]  <= r_tag[i-1];
            end
        end
    end

    unload_skid_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk      (clk),
        .i_resetn (i_resetn),
        .i_push   (r_pipe[SRAM_LAT-1]),
        .i_din    ({r_tag[SRAM_LAT-1], i_sram_rd_data}),
        .i_pop    (w_pop),
        .o_dout   (w_dout),
        .o_count  (w_count),
        .o_empty  (w_empty)
    );

endmodule

// File: tb/tb_fft_result_unloader.sv
// tb_fft_result_unloader: directed bench with an SRAM model and an order/credit/data model.
module tb_fft_result_unloader;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  cfg = '0;
    logic        done = 1'b0;
    logic        rreg = 1'b0;
    logic        rd_en, bank, ready = 1'b0, valid, last, busy, udone;
    logic [9:0]  addr;
    logic [31:0] rdata, data;

    always #5 clk = ~clk;

    fft_result_unloader #(.DATA_W(32), .SRAM_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .i_resetn(rstn), .i_point_configuration(cfg), .i_fft_done(done),
        .i_sram_read_register(rreg), .o_sram_rd_en(rd_en), .o_sram_rd_bank(bank),
        .o_sram_rd_addr(addr), .i_sram_rd_data(rdata), .o_data(data), .o_valid(valid),
        .i_ready(ready), .o_last(last), .o_busy(busy), .o_unload_done(udone)
    );

    function automatic logic [31:0] sram_word(input logic b, input logic [9:0] a);
        return {b ? 8'hB1 : 8'hA0, 4'h5, a, ~a};
    endfunction

    logic [32:0] sp [LAT];
    always @(posedge clk) begin
        sp[0] <= {rd_en, sram_word(bank, addr)};
        for (int i = 1; i < LAT; i++) sp[i] <= sp[i-1];
    end
    assign rdata = sp[LAT-1][32] ? sp[LAT-1][31:0] : 32'hDEADBEEF;

    int checks = 0, errors = 0;
    int issued, beats, lasts, cyc = 0, first_rd, last_rd, exp_n, exp_log2n, rmode = 0;
    logic exp_bank;
    bit mon_en = 0, nogap = 0, done_pend = 0, prev_v = 0, prev_r = 0, prev_l = 0;
    logic [31:0] prev_d, first_data, last_data;
    int rd_log [$];
`ifdef FFT_UNLOAD_BITREV_EN
    int exp_seq [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    int exp_seq [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic int exp_addr(input int k);
        int r = k;
`ifdef FFT_UNLOAD_BITREV_EN
        r = 0;
        for (int b = 0; b < exp_log2n; b++)
            if (k[b]) r |= 1 << (exp_log2n - 1 - b);
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (done_pend) begin
                chk("done_after_last", {busy, udone}, 2'b01);
                done_pend = 0;
            end
            if (prev_v && !prev_r) begin
                chk("hold_valid", valid, 1);
                chk("hold_data", data, prev_d);
                chk("hold_last", last, prev_l);
            end
            if (rd_en) begin
                chk("rd_addr", addr, exp_addr(issued));
                chk("rd_bank", bank, exp_bank);
                chk("credit", (issued - beats) < DEPTH, 1);
                if (issued == 0) first_rd = cyc;
                last_rd = cyc;
                rd_log.push_back(int'(addr));
                issued++;
            end
            if (nogap && beats > 0 && beats < exp_n) chk("no_gap", valid, 1);
            if (valid && ready) begin
                chk("beat_data", data, sram_word(exp_bank, 10'(exp_addr(beats))));
                chk("beat_last", last, beats == exp_n - 1);
                if (beats == 0) first_data = data;
                last_data = data;
                if (last) begin
                    lasts++;
                    chk("busy_at_last", {busy, udone}, 2'b10);
                    done_pend = 1;
                end
                beats++;
            end
            prev_v = valid; prev_r = ready; prev_d = data; prev_l = last;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        case (rmode)
            0: ready = 1'b1;
            1: ready = ($urandom_range(0, 9) < 3);
            default: ready = ~ready;
        endcase
    end

    task automatic do_reset(input bit lvl);
        mon_en = 0; rstn = 0; done = lvl;
        repeat (3) @(posedge clk);
        #1 rstn = 1;
    endtask

    task automatic arm_setup(input int c, input bit b, input int mode, input bit ng);
        cfg = 3'(c); rreg = b; rmode = mode; nogap = ng;
        exp_n = 8 << c; exp_log2n = c + 3; exp_bank = b;
        issued = 0; beats = 0; lasts = 0; done_pend = 0; prev_v = 0;
        rd_log.delete();
        mon_en = 1;
    endtask

    task automatic raise_done();
        @(posedge clk); #1 done = 1;
    endtask

    task automatic finish_unload(input string nm, input int budget);
        int k = 0;
        while (!udone && k < budget) begin @(negedge clk); k++; end
        chk({nm, "_done"}, udone, 1);
        chk({nm, "_beats"}, beats, exp_n);
        chk({nm, "_issued"}, issued, exp_n);
        chk({nm, "_lasts"}, lasts, 1);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, valid, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_udone"}, udone, 0);
        chk({nm, "_rd_en"}, rd_en, 0);
        chk({nm, "_addr"}, addr, 0);
        chk({nm, "_bank"}, bank, 0);
        chk({nm, "_data"}, data, 0);
        chk({nm, "_last"}, last, 0);
    endtask

    initial begin
        int lat, k;
        // Test 1: N=8, always ready, latency and literal pins
        do_reset(0);
        @(negedge clk);
        chk_zero("reset");
        arm_setup(0, 0, 0, 1);
        raise_done();
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid) begin lat = i; break; end
        end
        chk("latency", lat, LAT + 2);
        finish_unload("n8", 100);
        chk("n8_b2b", last_rd - first_rd, 7);
        chk("n8_rd_count", rd_log.size(), 8);
        for (int i = 0; i < rd_log.size() && i < 8; i++) chk("n8_rd_order", rd_log[i], exp_seq[i]);
        chk("n8_first_data", first_data, 32'hA05003FF);
        chk("n8_last_data", last_data, 32'hA0501FF8);

        // Test 2: N=1024, always ready, no gaps
        do_reset(0);
        arm_setup(7, 0, 0, 1);
        raise_done();
        finish_unload("n1024", 1200);
        chk("n1024_b2b", last_rd - first_rd, 1023);
        chk("n1024_last_data", last_data, 32'hA05FFC00);

        // Test 3: N=64, 30% ready, fft_done already high at reset release
        do_reset(1);
        arm_setup(3, 1, 1, 0);
        finish_unload("n64_rand", 3000);

        // Test 4: bank/cfg change after arm ignored, ready toggling
        do_reset(0);
        arm_setup(2, 1, 2, 0);
        raise_done();
        repeat (10) @(negedge clk);
        rreg = 0; cfg = 3'd0;
        finish_unload("bank", 500);

        // Test 5: reset at beat 20 of N=128, then restart from address 0
        do_reset(0);
        arm_setup(4, 0, 0, 0);
        raise_done();
        k = 0;
        while (beats < 20 && k < 200) begin @(negedge clk); k++; end
        chk("mid_reached20", beats, 20);
        #2 mon_en = 0; rstn = 0;
        #1 chk_zero("mid_reset");
        done = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        repeat (2) @(negedge clk);
        chk("after_reset_idle", busy, 0);
        arm_setup(4, 0, 0, 0);
        raise_done();
        k = 0;
        while (!rd_en && k < 20) begin @(negedge clk); k++; end
        chk("restart_addr", {rd_en, addr}, 11'h400);
        finish_unload("restart", 400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
